// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared pose constants, animation state enum, transparency index
package sprite_pkg;

  localparam logic [2:0] POSE_IDLE  = 3'd0;
  localparam logic [2:0] POSE_PUNCH = 3'd1;
  localparam logic [2:0] POSE_JUMP  = 3'd2;
  localparam logic [2:0] POSE_KICK  = 3'd3;

  localparam int TRANSPARENT_IDX = 0;

  typedef enum logic [1:0] {
    LOOP    = 2'd0,
    PENDING = 2'd1,
    ONESHOT = 2'd2
  } anim_state_t;

endpackage

// File: rtl/sprite_palette.sv
// rtl/sprite_palette.sv - combinational palette index to 12-bit RGB lookup
module sprite_palette #(
  parameter int PIX_W = 4
) (
  input  logic [PIX_W-1:0] idx,
  output logic [11:0]      rgb
);

  // Fixed 16-entry colour table; index 0 is never shown (transparent).
  always_comb begin
    rgb = 12'h000;
    case (int'(idx))
      1:       rgb = 12'hFFF;
      2:       rgb = 12'hF00;
      3:       rgb = 12'h0F0;
      4:       rgb = 12'h00F;
      5:       rgb = 12'hFC8;
      6:       rgb = 12'hFF0;
      7:       rgb = 12'h0FF;
      8:       rgb = 12'hF0F;
      9:       rgb = 12'h840;
      10:      rgb = 12'h888;
      11:      rgb = 12'h444;
      12:      rgb = 12'hF80;
      13:      rgb = 12'h08F;
      14:      rgb = 12'h8F0;
      15:      rgb = 12'hC0C;
      default: rgb = 12'h000;
    endcase
  end

endmodule

// File: rtl/fighter_sprite_engine.sv
// rtl/fighter_sprite_engine.sv - pose animation FSM and 3-stage sprite pixel path (option: SPRITE_FLIP_EN)
module fighter_sprite_engine
  import sprite_pkg::*;
#(
  parameter int NUM_POSES       = 4,
  parameter int FRAMES_PER_POSE = 4,
  parameter int HOLD_TICKS      = 6,
  parameter int SPR_W           = 64,
  parameter int SPR_H           = 96,
  parameter int PIX_W           = 4,
  parameter int ADDR_W          = 17,
  localparam int FRAME_W = (FRAMES_PER_POSE > 1) ? $clog2(FRAMES_PER_POSE) : 1
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               action_valid,
  input  logic [2:0]         action_pose,
  output logic               busy,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic [9:0]         PosX,
  input  logic [9:0]         PosY,
  input  logic               blank,
`ifdef SPRITE_FLIP_EN
  input  logic               facing_left,
`endif
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [PIX_W-1:0]   rom_data,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               sprite_on,
  output logic [2:0]         cur_pose,
  output logic [FRAME_W-1:0] cur_frame
);

  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [9:0] SPR_W10 = 10'(SPR_W);
  localparam logic [9:0] SPR_H10 = 10'(SPR_H);

  anim_state_t        state, state_n;
  logic [2:0]         pending, pending_n, cur_pose_n;
  logic [FRAME_W-1:0] frame_n;
  logic [HOLD_W-1:0]  hold, hold_n;
  logic               req_ok, hold_last, frame_last;

  assign req_ok     = action_valid && (action_pose != POSE_IDLE) &&
                      (32'(action_pose) < 32'(NUM_POSES));
  assign hold_last  = (hold == HOLD_W'(HOLD_TICKS - 1));
  assign frame_last = (cur_frame == FRAME_W'(FRAMES_PER_POSE - 1));
  assign busy       = (state != LOOP);

  // Animation state register; reset drops any move in progress back to idle.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state     <= LOOP;
      pending   <= POSE_IDLE;
      cur_pose  <= POSE_IDLE;
      cur_frame <= '0;
      hold      <= '0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      cur_pose  <= cur_pose_n;
      cur_frame <= frame_n;
      hold      <= hold_n;
    end
  end

  // Next-state logic: requests land any cycle, but pose/frame only move on frame_tick.
  always_comb begin
    state_n    = state;
    pending_n  = pending;
    cur_pose_n = cur_pose;
    frame_n    = cur_frame;
    hold_n     = hold;
    case (state)
      LOOP: begin
        if (req_ok) begin
          state_n   = PENDING;
          pending_n = action_pose;
        end
        if (frame_tick) begin
          if (hold_last) begin
            hold_n  = '0;
            frame_n = frame_last ? '0 : cur_frame + 1'b1;
          end else begin
            hold_n = hold + 1'b1;
          end
        end
      end
      PENDING: begin
        if (frame_tick) begin
          state_n    = ONESHOT;
          cur_pose_n = pending;
          frame_n    = '0;
          hold_n     = '0;
        end
      end
      ONESHOT: begin
        if (frame_tick) begin
          if (hold_last) begin
            hold_n = '0;
            if (frame_last) begin
              state_n    = LOOP;
              cur_pose_n = POSE_IDLE;
              frame_n    = '0;
            end else begin
              frame_n = cur_frame + 1'b1;
            end
          end else begin
            hold_n = hold + 1'b1;
          end
        end
      end
      default: state_n = LOOP;
    endcase
  end

  logic [9:0]       dx, dy, dx_eff;
  logic             in_box, valid1, valid2;
  logic [11:0]      pal_rgb;

  // Stage 0: sprite-relative coordinates; wraparound is intentional, no clipping.
  always_comb begin
    dx     = DrawX - PosX;
    dy     = DrawY - PosY;
    in_box = (dx < SPR_W10) && (dy < SPR_H10) && blank;
`ifdef SPRITE_FLIP_EN
    dx_eff = facing_left ? (SPR_W10 - 10'd1 - dx) : dx;
`else
    dx_eff = dx;
`endif
  end

  sprite_palette #(.PIX_W(PIX_W)) u_palette (
    .idx (rom_data),
    .rgb (pal_rgb)
  );

  // Stages 1-3: issue ROM address, track validity alongside the ROM read, then key out index 0.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_addr  <= '0;
      valid1    <= 1'b0;
      valid2    <= 1'b0;
      sprite_on <= 1'b0;
      red       <= 4'h0;
      green     <= 4'h0;
      blue      <= 4'h0;
    end else begin
      rom_addr  <= ADDR_W'(((32'(cur_pose) * 32'(FRAMES_PER_POSE) + 32'(cur_frame)) *
                   32'(SPR_H) + 32'(dy)) * 32'(SPR_W) + 32'(dx_eff));
      valid1    <= in_box;
      valid2    <= valid1;
      if (valid2 && (rom_data != PIX_W'(TRANSPARENT_IDX))) begin
        sprite_on <= 1'b1;
        {red, green, blue} <= pal_rgb;
      end else begin
        sprite_on <= 1'b0;
        {red, green, blue} <= 12'h000;
      end
    end
  end

endmodule
